// File: rtl/ccff_pkg.sv
// Shared types and CRC helpers for the ccff chain loader.
// CRC-16-CCITT constants and a one-bit serial update step.
package ccff_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOAD   = 2'd1,
        ST_VERIFY = 2'd2,
        ST_FINISH = 2'd3
    } state_e;

    localparam logic [15:0] CRC_POLY = 16'h1021;
    localparam logic [15:0] CRC_INIT = 16'hFFFF;

    function automatic logic [15:0] crc16_step(
        input logic [15:0] crc,
        input logic        b
    );
        logic fb;
        fb = crc[15] ^ b;
        return {crc[14:0], 1'b0} ^ (fb ? CRC_POLY : 16'h0000);
    endfunction

endpackage

// File: rtl/ccff_crc16.sv
// Serial CRC-16-CCITT accumulator, MSB-first, one bit per enabled cycle.
// A clear returns the state to the init value ahead of a new run.
import ccff_pkg::*;

module ccff_crc16 (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        clr_i,
    input  logic        en_i,
    input  logic        bit_i,
    output logic [15:0] crc_o
);

    logic [15:0] crc_q;
    logic [15:0] crc_d;

    always_comb begin
        crc_d = crc_q;
        if (clr_i) begin
            crc_d = CRC_INIT;
        end else if (en_i) begin
            crc_d = crc16_step(crc_q, bit_i);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            crc_q <= CRC_INIT;
        end else begin
            crc_q <= crc_d;
        end
    end

    assign crc_o = crc_q;

endmodule

// File: rtl/ccff_loader.sv
// Streams bitstream words into a ccff chain, then recirculates the chain
// once to check its contents against the CRC of what was shifted in.
import ccff_pkg::*;

module ccff_loader #(
    parameter int CHAIN_LEN = 42,
    parameter int WORD_W    = 8
) (
    input  logic              prog_clk,
    input  logic              pReset,
    input  logic              start,
    input  logic [WORD_W-1:0] din,
    input  logic              din_valid,
    output logic              din_ready,
    output logic              ccff_head,
    output logic              shift_en,
    input  logic              ccff_tail,
    output logic              busy,
    output logic              done,
    output logic              crc_err
);

    localparam int CW = $clog2(CHAIN_LEN + 1);
    localparam int BW = $clog2(WORD_W + 1);
    localparam logic [CW-1:0] LAST = CW'(CHAIN_LEN - 1);

    state_e            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [WORD_W-1:0] word_q, word_d;
    logic [BW-1:0]     bits_q, bits_d;
    logic              err_q, err_d;

    logic        crc_clr;
    logic        tx_en;
    logic        rx_en;
    logic [15:0] crc_tx;
    logic [15:0] crc_rx;
    logic        mismatch;

    assign mismatch = (crc_rx != crc_tx);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        word_d    = word_q;
        bits_d    = bits_q;
        err_d     = err_q;
        shift_en  = 1'b0;
        ccff_head = 1'b0;
        din_ready = 1'b0;
        crc_clr   = 1'b0;
        tx_en     = 1'b0;
        rx_en     = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_LOAD;
                    cnt_d   = '0;
                    bits_d  = '0;
                    word_d  = '0;
                    err_d   = 1'b0;
                    crc_clr = 1'b1;
                end
            end
            ST_LOAD: begin
                din_ready = (bits_q == '0);
                shift_en  = (bits_q != '0);
                ccff_head = shift_en & word_q[0];
                tx_en     = shift_en;
                if (shift_en) begin
                    word_d = word_q >> 1;
                    bits_d = bits_q - BW'(1);
                    cnt_d  = cnt_q + CW'(1);
                    // Leftover bits of a partial final word are dropped here.
                    if (cnt_q == LAST) begin
                        state_d = ST_VERIFY;
                        cnt_d   = '0;
                        bits_d  = '0;
                        word_d  = '0;
                    end
                end else if (din_valid) begin
                    word_d = din;
                    bits_d = BW'(WORD_W);
                end
            end
            ST_VERIFY: begin
                shift_en  = 1'b1;
                ccff_head = ccff_tail;
                rx_en     = 1'b1;
                cnt_d     = cnt_q + CW'(1);
                if (cnt_q == LAST) begin
                    state_d = ST_FINISH;
                    cnt_d   = '0;
                end
            end
            ST_FINISH: begin
                state_d = ST_IDLE;
                err_d   = err_q | mismatch;
                cnt_d   = '0;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge prog_clk) begin
        if (!pReset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            word_q  <= '0;
            bits_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            word_q  <= word_d;
            bits_q  <= bits_d;
            err_q   <= err_d;
        end
    end

    ccff_crc16 u_crc_tx (
        .clk_i  (prog_clk),
        .rst_ni (pReset),
        .clr_i  (crc_clr),
        .en_i   (tx_en),
        .bit_i  (ccff_head),
        .crc_o  (crc_tx)
    );

    ccff_crc16 u_crc_rx (
        .clk_i  (prog_clk),
        .rst_ni (pReset),
        .clr_i  (crc_clr),
        .en_i   (rx_en),
        .bit_i  (ccff_tail),
        .crc_o  (crc_rx)
    );

    assign busy    = (state_q != ST_IDLE);
    assign done    = (state_q == ST_FINISH);
    // The mismatch is visible alongside done, then held sticky.
    assign crc_err = err_q | (done & mismatch);

endmodule

// File: tb/tb_ccff_loader.sv
// Bench for ccff_loader: chain models, directed loads, scoreboard on done.
// Covers streaming, stalls, corrupted readback, reset abort and short chains.
module tb_ccff_loader;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       start;
    logic [7:0] din;
    logic       din_valid;
    logic       din_ready, head, shift_en, tail, busy, done, crc_err;

    logic       start5;
    logic [7:0] din5;
    logic       din_valid5;
    logic       din_ready5, head5, shift_en5, tail5, busy5, done5, crc_err5;

    ccff_loader #(.CHAIN_LEN(42), .WORD_W(8)) u_dut (
        .prog_clk  (clk),
        .pReset    (rst_n),
        .start     (start),
        .din       (din),
        .din_valid (din_valid),
        .din_ready (din_ready),
        .ccff_head (head),
        .shift_en  (shift_en),
        .ccff_tail (tail),
        .busy      (busy),
        .done      (done),
        .crc_err   (crc_err)
    );

    ccff_loader #(.CHAIN_LEN(5), .WORD_W(8)) u_dut5 (
        .prog_clk  (clk),
        .pReset    (rst_n),
        .start     (start5),
        .din       (din5),
        .din_valid (din_valid5),
        .din_ready (din_ready5),
        .ccff_head (head5),
        .shift_en  (shift_en5),
        .ccff_tail (tail5),
        .busy      (busy5),
        .done      (done5),
        .crc_err   (crc_err5)
    );

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    task automatic fail_now(input string nm);
        checks++;
        failures++;
        $display("FAIL %s timeout", nm);
    endtask

    // 42-flop chain model with optional single-flop corruption
    localparam logic [41:0] FLIPM = 42'h1 << 30;
    logic [41:0] chain = '0;
    logic        flip  = 1'b0;
    int          shifts = 0;
    assign tail = chain[41];

    always @(posedge clk) begin
        if (shift_en) begin
            chain  <= {chain[40:0], head} ^ (flip ? FLIPM : 42'd0);
            shifts <= shifts + 1;
        end
    end

    // 5-flop chain model recording the loaded head bits
    logic [4:0] chain5 = '0;
    logic [4:0] hb     = '0;
    int         sh5    = 0;
    assign tail5 = chain5[4];

    always @(posedge clk) begin
        if (shift_en5) begin
            chain5 <= {chain5[3:0], head5};
            if (sh5 < 5) hb[sh5] <= head5;
            sh5 <= sh5 + 1;
        end
    end

    typedef struct {
        logic        err;
        logic [41:0] chain;
        int          end_shifts;
        bit          chk_chain;
    } exp_t;

    typedef struct {
        logic [4:0] heads;
        int         shifts;
        logic [4:0] chain;
    } exp5_t;

    exp_t  q[$];
    exp5_t q5[$];
    exp_t  e;
    exp5_t e5;
    int    dones  = 0;
    int    dones5 = 0;

    always @(negedge clk) begin
        if (done) begin
            dones++;
            if (q.size() == 0) begin
                fail_now("unexpected_done");
            end else begin
                e = q.pop_front();
                chk("crc_err_at_done", 64'(crc_err), 64'(e.err));
                chk("shift_total", 64'(shifts), 64'(e.end_shifts));
                if (e.chk_chain)
                    chk("chain_contents", 64'(chain), 64'(e.chain));
            end
        end
        if (done5) begin
            dones5++;
            if (q5.size() == 0) begin
                fail_now("unexpected_done5");
            end else begin
                e5 = q5.pop_front();
                chk("c5_head_bits", 64'(hb), 64'(e5.heads));
                chk("c5_shift_total", 64'(sh5), 64'(e5.shifts));
                chk("c5_chain", 64'(chain5), 64'(e5.chain));
                chk("c5_crc_err", 64'(crc_err5), 64'(1'b0));
            end
        end
    end

    logic [7:0] w [6];

    function automatic logic [41:0] expect_chain();
        logic [41:0] c;
        c = '0;
        for (int k = 0; k < 42; k++) c[41-k] = w[k/8][k%8];
        return c;
    endfunction

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send(input logic [7:0] wd);
        int n;
        din       = wd;
        din_valid = 1'b1;
        n = 0;
        while (!din_ready && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (n >= 300) fail_now("send_ready");
        @(negedge clk);
        din_valid = 1'b0;
    endtask

    task automatic wait_shifts(input int target);
        int n;
        n = 0;
        while (shifts < target && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (shifts < target) fail_now("wait_shifts");
    endtask

    task automatic wait_done(input int d0);
        int n;
        n = 0;
        while (dones == d0 && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (dones == d0) fail_now("wait_done");
    endtask

    task automatic run_load(input bit stall, input bit do_flip,
                            input bit start_in_verify);
        int   base, d0, s0, n;
        bit   se_seen;
        exp_t x;
        base = shifts;
        d0   = dones;
        x.err        = do_flip;
        x.chain      = expect_chain();
        x.end_shifts = base + 84;
        x.chk_chain  = !do_flip;
        q.push_back(x);
        pulse_start();
        chk("crc_err_clear_on_start", 64'(crc_err), 64'(1'b0));
        chk("busy_in_load", 64'(busy), 64'(1'b1));
        for (int i = 0; i < 6; i++) begin
            send(w[i]);
            if (stall && i == 2) begin
                n = 0;
                while (!din_ready && n < 50) begin
                    @(negedge clk);
                    n++;
                end
                s0 = shifts;
                se_seen = 1'b0;
                repeat (5) begin
                    if (shift_en) se_seen = 1'b1;
                    @(negedge clk);
                end
                chk("stall_shift_en", 64'(se_seen), 64'(1'b0));
                chk("stall_chain_held", 64'(shifts), 64'(s0));
            end
        end
        if (do_flip || start_in_verify) begin
            wait_shifts(base + 52);
            flip  = do_flip;
            start = start_in_verify;
            @(negedge clk);
            flip  = 1'b0;
            start = 1'b0;
        end
        wait_done(d0);
        repeat (20) @(negedge clk);
        chk("one_done_pulse", 64'(dones), 64'(d0 + 1));
        chk("idle_after_done", 64'(busy), 64'(1'b0));
        chk("crc_err_sticky", 64'(crc_err), 64'(do_flip));
    endtask

    initial begin
        int    base, s1, d0, n;
        exp5_t x5;
        rst_n      = 1'b0;
        start      = 1'b0;
        din        = '0;
        din_valid  = 1'b0;
        start5     = 1'b0;
        din5       = '0;
        din_valid5 = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_busy", 64'(busy), 64'(1'b0));
        chk("rst_done", 64'(done), 64'(1'b0));
        chk("rst_din_ready", 64'(din_ready), 64'(1'b0));
        chk("rst_shift_en", 64'(shift_en), 64'(1'b0));
        chk("rst_head", 64'(head), 64'(1'b0));
        chk("rst_crc_err", 64'(crc_err), 64'(1'b0));

        // Short chain: only bits 0..4 of 0xA5 reach the chain
        x5.heads  = 5'b00101;
        x5.shifts = 10;
        x5.chain  = 5'b10100;
        q5.push_back(x5);
        start5 = 1'b1;
        @(negedge clk);
        start5     = 1'b0;
        din5       = 8'hA5;
        din_valid5 = 1'b1;
        n = 0;
        while (!din_ready5 && n < 50) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        din_valid5 = 1'b0;
        n = 0;
        while (dones5 == 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (dones5 == 0) fail_now("c5_wait_done");
        repeat (5) @(negedge clk);
        chk("c5_idle", 64'(busy5), 64'(1'b0));

        w = '{8'h3C, 8'hA5, 8'h0F, 8'hF0, 8'h5A, 8'hC3};
        run_load(1'b0, 1'b0, 1'b0);

        w = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC};
        run_load(1'b1, 1'b0, 1'b0);

        w = '{8'hFF, 8'h00, 8'h81, 8'h7E, 8'h55, 8'hAA};
        run_load(1'b0, 1'b1, 1'b0);

        w = '{8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h01, 8'h02};
        run_load(1'b0, 1'b0, 1'b1);

        // Reset partway through LOAD
        base = shifts;
        d0   = dones;
        pulse_start();
        send(8'h11);
        send(8'h22);
        send(8'h33);
        wait_shifts(base + 20);
        rst_n = 1'b0;
        @(negedge clk);
        chk("abort_busy", 64'(busy), 64'(1'b0));
        chk("abort_shift_en", 64'(shift_en), 64'(1'b0));
        chk("abort_din_ready", 64'(din_ready), 64'(1'b0));
        s1 = shifts;
        rst_n = 1'b1;
        repeat (60) @(negedge clk);
        chk("abort_no_more_shifts", 64'(shifts), 64'(s1));
        chk("abort_no_done", 64'(dones), 64'(d0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
